// File: rtl/onehot_dec_pkg.sv
// -----------------------------------------------------------------------------
// onehot_dec_pkg
// Shared definitions for the one-hot strobe decoder slice.
//   OUT_W / IDX_W : width of the one-hot output bus and of the binary index
//   CNT_W         : width of the shared pulse/gap down-counter
//   state_t       : decoder FSM states (IDLE, PULSE, GAP)
//   idx_to_onehot : binary index -> one-hot vector
// -----------------------------------------------------------------------------
package onehot_dec_pkg;

    localparam int OUT_W = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// -----------------------------------------------------------------------------
// sync_fifo_small
// Small synchronous FIFO with a flush input. Full/empty come from read and
// write pointers that carry one extra wrap bit.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : synchronous clear of all entries
//   push, push_data: write request (ignored while full) and its data
//   pop, pop_data  : read request (ignored while empty); pop_data shows the
//                    head entry combinationally
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo_small #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same slot, different lap: the writer is a full buffer ahead of the reader.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: clocked state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, so clearing it would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// -----------------------------------------------------------------------------
// onehot_strobe_decoder
// Accepts 4-bit line indices over valid/ready, queues them, and for each one
// drives the matching line of a 16-bit registered one-hot bus for PULSE_LEN
// cycles, followed by GAP_LEN forced-zero cycles.
//   clk, rst   : clock, synchronous active-high reset (priority over enable)
//   enable     : low aborts the current pulse and flushes the queue
//   in_valid   : index offered
//   in_ready   : queue can accept (!full && enable)
//   in_index   : binary line number 0..15
//   onehot_out : registered one-hot strobe, zero when idle
//   out_active : onehot_out is non-zero
//   busy       : FSM not IDLE or queue not empty
// -----------------------------------------------------------------------------
module onehot_strobe_decoder
    import onehot_dec_pkg::*;
#(
    parameter int PULSE_LEN  = 4,
    parameter int GAP_LEN    = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    output logic [OUT_W-1:0] onehot_out,
    output logic             out_active,
    output logic             busy
);

    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_CNT   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [OUT_W-1:0] onehot_nx;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_flush;
    logic [IDX_W-1:0] head_idx;

    assign in_ready   = !fifo_full && enable;
    assign fifo_push  = in_valid && in_ready;
    assign fifo_flush = !enable;

    sync_fifo_small #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (in_index),
        .pop       (fifo_pop),
        .pop_data  (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        onehot_nx = onehot_out;
        fifo_pop  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    onehot_nx = idx_to_onehot(head_idx);
                    cnt_nx    = PULSE_CNT;
                    state_nx  = PULSE;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (GAP_LEN > 0) begin
                    onehot_nx = '0;
                    cnt_nx    = GAP_CNT;
                    state_nx  = GAP;
                end else if (!fifo_empty) begin
                    // No gap configured: chain straight into the next pulse.
                    fifo_pop  = 1'b1;
                    onehot_nx = idx_to_onehot(head_idx);
                    cnt_nx    = PULSE_CNT;
                end else begin
                    onehot_nx = '0;
                    state_nx  = IDLE;
                end
            end
            GAP: begin
                onehot_nx = '0;
                if (cnt != '0) cnt_nx   = cnt - CNT_W'(1);
                else           state_nx = IDLE;
            end
            default: begin
                onehot_nx = '0;
                cnt_nx    = '0;
                state_nx  = IDLE;
            end
        endcase

        // Disable truncates whatever is in flight, with no trailing gap.
        if (!enable) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            onehot_nx = '0;
            fifo_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            onehot_out <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            onehot_out <= onehot_nx;
        end
    end

    assign out_active = |onehot_out;
    assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_strobe_decoder
// Three decoder instances with different pulse/gap/depth settings. A timeline
// model (queue contents plus the edge numbers at which each pulse ends, the
// block goes quiet, and the next pop is allowed) predicts every output after
// every edge; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_onehot_strobe_decoder;

    localparam int NI = 3;
    localparam int P0 = 4, G0 = 1, D0 = 2;
    localparam int P1 = 1, G1 = 0, D1 = 4;
    localparam int P2 = 8, G2 = 1, D2 = 2;
    localparam int PL [NI] = '{P0, P1, P2};
    localparam int GL [NI] = '{G0, G1, G2};
    localparam int DP [NI] = '{D0, D1, D2};

    localparam logic [15:0] T1_OH   [8] = '{16'h0000, 16'h0020, 16'h0020, 16'h0020,
                                            16'h0020, 16'h0000, 16'h0000, 16'h0000};
    localparam logic        T1_BUSY [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        T4_RDY  [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] T4_OH   [13] = '{16'h0000, 16'h0200, 16'h0200, 16'h0200,
                                             16'h0200, 16'h0200, 16'h0200, 16'h0200,
                                             16'h0200, 16'h0000, 16'h0000, 16'h0200,
                                             16'h0200};

    logic        clk;
    logic        rst [NI];
    logic        en  [NI];
    logic        vld [NI];
    logic [3:0]  idx [NI];
    logic        rdy [NI];
    logic        act [NI];
    logic        bsy [NI];
    logic [15:0] oh  [NI];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, written only by the compare process.
    int         cyc;
    int         qn     [NI];
    logic [3:0] qd     [NI][4];
    int         cur    [NI];
    int         plast  [NI];
    int         buntil [NI];
    int         npop   [NI];

    onehot_strobe_decoder #(.PULSE_LEN(P0), .GAP_LEN(G0), .FIFO_DEPTH(D0)) u0 (
        .clk(clk), .rst(rst[0]), .enable(en[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_index(idx[0]), .onehot_out(oh[0]), .out_active(act[0]), .busy(bsy[0]));
    onehot_strobe_decoder #(.PULSE_LEN(P1), .GAP_LEN(G1), .FIFO_DEPTH(D1)) u1 (
        .clk(clk), .rst(rst[1]), .enable(en[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_index(idx[1]), .onehot_out(oh[1]), .out_active(act[1]), .busy(bsy[1]));
    onehot_strobe_decoder #(.PULSE_LEN(P2), .GAP_LEN(G2), .FIFO_DEPTH(D2)) u2 (
        .clk(clk), .rst(rst[2]), .enable(en[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_index(idx[2]), .onehot_out(oh[2]), .out_active(act[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
    endtask

    // Advance the model for instance i across edge m using the pre-edge inputs.
    task automatic model_edge(input int i, input int m);
        bit take;
        if (rst[i] || !en[i]) begin
            qn[i] = 0; plast[i] = -1; buntil[i] = -1; npop[i] = 0;
        end else begin
            take = vld[i] && (qn[i] < DP[i]);
            if (qn[i] > 0 && m >= npop[i]) begin
                cur[i] = qd[i][0];
                for (int k = 0; k < 3; k++) qd[i][k] = qd[i][k+1];
                qn[i]--;
                plast[i]  = m + PL[i] - 1;
                buntil[i] = m + PL[i] + GL[i] - 1;
                npop[i]   = m + PL[i] + ((GL[i] > 0) ? GL[i] + 1 : 0);
            end
            if (take) begin
                qd[i][qn[i]] = idx[i];
                qn[i]++;
            end
        end
    endtask

    // Compare process: model every edge, check all outputs 1 time unit later.
    initial begin
        logic [15:0] exp_oh;
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            qn[i] = 0; cur[i] = 0; plast[i] = -1; buntil[i] = -1; npop[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) model_edge(i, cyc);
            #1;
            for (int i = 0; i < NI; i++) begin
                exp_oh = (cyc <= plast[i]) ? (16'(1) << cur[i]) : 16'h0000;
                check($sformatf("u%0d onehot_out", i), 32'(oh[i]), 32'(exp_oh));
                check($sformatf("u%0d out_active", i), 32'(act[i]), 32'(exp_oh != 0));
                check($sformatf("u%0d busy", i), 32'(bsy[i]),
                      32'((cyc <= buntil[i]) || (qn[i] > 0)));
                check($sformatf("u%0d in_ready", i), 32'(rdy[i]),
                      32'(en[i] && (qn[i] < DP[i])));
            end
            cyc++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int i, input int budget);
        for (int c = 0; c < budget && bsy[i]; c++) tick();
        check($sformatf("u%0d drain", i), 32'(bsy[i]), 32'(0));
    endtask

    initial begin
        logic [15:0] seq [16];
        logic [15:0] prev;
        int          nxt;
        int          seen;
        bit          blocked;
        bit          accepted;

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; en[i] = 1'b1; vld[i] = 1'b0; idx[i] = 4'd0;
        end
        repeat (3) tick();
        check("reset onehot_out", 32'(oh[0]), 32'h0);
        check("reset busy", 32'(bsy[0]), 32'h0);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        tick();
        check("ready after reset", 32'(rdy[0]), 32'h1);

        // Single push of index 5 with the default settings.
        vld[0] = 1'b1; idx[0] = 4'd5;
        for (int k = 0; k < 8; k++) begin
            tick();
            vld[0] = 1'b0;
            check($sformatf("t1 onehot k=%0d", k), 32'(oh[0]), 32'(T1_OH[k]));
            check($sformatf("t1 busy k=%0d", k), 32'(bsy[0]), 32'(T1_BUSY[k]));
        end

        // Sweep 0..15 with valid held; collect the pulse sequence.
        for (int k = 0; k < 16; k++) seq[k] = '0;
        nxt = 0; seen = 0; prev = '0; blocked = 0;
        for (int c = 0; c < 300 && (nxt < 16 || bsy[0]); c++) begin
            vld[0] = (nxt < 16);
            idx[0] = 4'(nxt);
            accepted = vld[0] && rdy[0];
            if (vld[0] && !rdy[0]) blocked = 1;
            tick();
            if (accepted) nxt++;
            if (oh[0] != 0 && oh[0] != prev && seen < 16) begin
                seq[seen] = oh[0];
                seen++;
            end
            prev = oh[0];
        end
        vld[0] = 1'b0;
        check("sweep pushes", 32'(nxt), 32'd16);
        check("sweep pulses", 32'(seen), 32'd16);
        check("sweep backpressure", 32'(blocked), 32'd1);
        for (int k = 0; k < 16; k++)
            check($sformatf("sweep pulse %0d", k), 32'(seq[k]), 32'(16'(1) << k));

        // Back-to-back mode: 3, 7, 12 on consecutive cycles.
        vld[1] = 1'b1; idx[1] = 4'd3;
        tick(); check("b2b e0", 32'(oh[1]), 32'h0000);
        idx[1] = 4'd7;
        tick(); check("b2b e1", 32'(oh[1]), 32'h0008);
        idx[1] = 4'd12;
        tick(); check("b2b e2", 32'(oh[1]), 32'h0080);
        vld[1] = 1'b0;
        tick(); check("b2b e3", 32'(oh[1]), 32'h1000);
        tick(); check("b2b e4", 32'(oh[1]), 32'h0000);

        // Full queue: index 9 held valid against an 8-cycle pulse, depth 2.
        vld[2] = 1'b1; idx[2] = 4'd9;
        for (int k = 0; k < 13; k++) begin
            tick();
            check($sformatf("full rdy k=%0d", k), 32'(rdy[2]), 32'(T4_RDY[k]));
            check($sformatf("full onehot k=%0d", k), 32'(oh[2]), 32'(T4_OH[k]));
        end
        vld[2] = 1'b0;
        wait_idle(2, 100);

        // Abort: enable low for one cycle in the 2nd pulse cycle, 2 queued.
        vld[0] = 1'b1; idx[0] = 4'd1;
        tick(); idx[0] = 4'd2;
        tick(); check("abort pulse c1", 32'(oh[0]), 32'h0002);
        idx[0] = 4'd3;
        tick(); check("abort pulse c2", 32'(oh[0]), 32'h0002);
        check("abort queue full", 32'(rdy[0]), 32'h0);
        en[0] = 1'b0; vld[0] = 1'b0;
        tick();
        check("abort onehot", 32'(oh[0]), 32'h0);
        check("abort busy", 32'(bsy[0]), 32'h0);
        check("abort ready", 32'(rdy[0]), 32'h0);
        en[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("abort stale k=%0d", k), 32'(oh[0]), 32'h0);
        end

        // Reset during a gap with entries queued, then a fresh push of 15.
        vld[0] = 1'b1; idx[0] = 4'd1;
        tick(); idx[0] = 4'd2;
        tick(); idx[0] = 4'd3;
        tick(); vld[0] = 1'b0;
        repeat (3) tick();
        check("gap onehot", 32'(oh[0]), 32'h0);
        check("gap busy", 32'(bsy[0]), 32'h1);
        rst[0] = 1'b1;
        tick();
        check("rst onehot", 32'(oh[0]), 32'h0);
        check("rst busy", 32'(bsy[0]), 32'h0);
        check("rst active", 32'(act[0]), 32'h0);
        check("rst ready", 32'(rdy[0]), 32'h1);
        rst[0] = 1'b0; vld[0] = 1'b1; idx[0] = 4'd15;
        tick(); vld[0] = 1'b0;
        check("post-rst e0", 32'(oh[0]), 32'h0);
        tick();
        check("post-rst e1", 32'(oh[0]), 32'h8000);
        wait_idle(0, 50);

        // Randomised traffic on all instances, alternating light and heavy load.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i] = ($urandom_range(0, 299) == 0);
                en[i]  = ($urandom_range(0, 59) != 0);
                vld[i] = (c & 256) != 0 ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 7) == 0);
                idx[i] = 4'($urandom_range(0, 15));
            end
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; en[i] = 1'b1; vld[i] = 1'b0;
        end
        for (int i = 0; i < NI; i++) wait_idle(i, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
